// File: rtl/data_ram_sized.sv
// MEM-stage data memory: little-endian byte/half/word stores with lane masking,
// sign/zero-extended sub-word loads, misalignment flag and a post-reset clear engine.
`timescale 1ns/1ps
module data_ram_sized #(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1,
  parameter int TEST_IDX       = 0,
  parameter int TEST_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       WD,
  input  logic              WE,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [31:0]       RD,
  output logic              busy,
  output logic              misalign,
  output logic [TEST_W-1:0] test
);

  localparam int AW = $clog2(DEPTH);
  localparam logic CLR_EN = (CLEAR_ON_RESET != 32'sd0);
  localparam logic [AW-1:0] TEST_IDX_C = AW'(TEST_IDX);
  localparam logic [AW-1:0] LAST_IDX_C = AW'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [AW-1:0]   clr_ptr_r, clr_ptr_s;
  logic [31:0]     ram_r [0:DEPTH-1];

  logic [AW-1:0]   idx_s;
  logic [4:0]      shamt_s;
  logic [31:0]     word_s, wmask_s, wdata_s, rd_s;
  logic [7:0]      byte_s;
  logic [15:0]     half_s;
  logic            busy_s, misalign_s, store_s, clearing_s;
  logic            unused_s;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic zero_ext);
    return {{24{b[7] & ~zero_ext}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic zero_ext);
    return {{16{h[15] & ~zero_ext}}, h};
  endfunction

  // Upper address bits are intentionally ignored: addresses wrap modulo 4*DEPTH.
  assign unused_s   = ^A;
  assign idx_s      = A[AW+1:2];
  assign shamt_s    = {A[1:0], 3'b000};
  assign word_s     = ram_r[idx_s];
  assign byte_s     = word_s[shamt_s +: 8];
  assign half_s     = A[1] ? word_s[31:16] : word_s[15:0];
  assign clearing_s = (state_r == CLEAR) && !reset;
  assign busy_s     = (state_r == CLEAR) || (reset && CLR_EN);
  assign store_s    = WE && !busy_s && !misalign_s && !reset;

  // Clear-engine next state; the final clear write returns to IDLE.
  always_comb begin
    state_s   = state_r;
    clr_ptr_s = clr_ptr_r;
    case (state_r)
      IDLE: begin
        state_s = IDLE;
      end
      CLEAR: begin
        clr_ptr_s = clr_ptr_r + AW'(1);
        if (clr_ptr_r == LAST_IDX_C) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset mid-clear restarts at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= CLR_EN ? CLEAR : IDLE;
      clr_ptr_r <= '0;
    end else begin
      state_r   <= state_s;
      clr_ptr_r <= clr_ptr_s;
    end
  end

  // Misalignment decode and store lane mask/data placement.
  always_comb begin
    misalign_s = 1'b1;
    wmask_s    = 32'h0000_0000;
    wdata_s    = 32'h0000_0000;
    case (size)
      2'b00: begin
        misalign_s = 1'b0;
        wmask_s    = 32'h0000_00FF << shamt_s;
        wdata_s    = {24'h00_0000, WD[7:0]} << shamt_s;
      end
      2'b01: begin
        misalign_s = A[0];
        wmask_s    = A[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata_s    = {WD[15:0], WD[15:0]};
      end
      2'b10: begin
        misalign_s = |A[1:0];
        wmask_s    = 32'hFFFF_FFFF;
        wdata_s    = WD;
      end
      default: begin
        misalign_s = 1'b1;
      end
    endcase
  end

  // Load path: lane select and extension, zeroed on illegal access or while clearing.
  always_comb begin
    rd_s = 32'h0000_0000;
    case (size)
      2'b00:   rd_s = ext8(byte_s, uns);
      2'b01:   rd_s = ext16(half_s, uns);
      2'b10:   rd_s = word_s;
      default: rd_s = 32'h0000_0000;
    endcase
    if (misalign_s || busy_s) begin
      rd_s = 32'h0000_0000;
    end else begin
      rd_s = rd_s;
    end
  end

  // Array update: clear engine has priority; stores merge only the selected lanes.
  always_ff @(posedge clk) begin
    if (clearing_s) begin
      ram_r[clr_ptr_r] <= 32'h0000_0000;
    end else if (store_s) begin
      ram_r[idx_s] <= (word_s & ~wmask_s) | (wdata_s & wmask_s);
    end
  end

  assign RD       = rd_s;
  assign busy     = busy_s;
  assign misalign = misalign_s;
  assign test     = ram_r[TEST_IDX_C][TEST_W-1:0];

endmodule

// File: tb/tb_data_ram_sized.sv
// Directed bench for data_ram_sized: clear timing, lanes, extension,
// misalignment, mid-clear reset, address wrap and CLEAR_ON_RESET=0.
`timescale 1ns/1ps
module tb_data_ram_sized;

  logic        clk;
  logic        reset, we, uns;
  logic [31:0] a, wd, rd;
  logic [1:0]  size;
  logic        busy, misalign;
  logic [15:0] test;

  logic        reset2, we2, uns2;
  logic [31:0] a2, wd2, rd2;
  logic [1:0]  size2;
  logic        busy2, mis2;
  logic [15:0] test2;

  int checks   = 0;
  int failures = 0;
  int n;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rd;
    logic        mis;
  } vec_t;

  vec_t vecs [23];

  data_ram_sized #(.DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(1), .TEST_IDX(0), .TEST_W(16)) dut (
    .clk(clk), .reset(reset), .A(a), .WD(wd), .WE(we), .size(size), .uns(uns),
    .RD(rd), .busy(busy), .misalign(misalign), .test(test)
  );

  data_ram_sized #(.DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(0), .TEST_IDX(0), .TEST_W(16)) dut_nc (
    .clk(clk), .reset(reset2), .A(a2), .WD(wd2), .WE(we2), .size(size2), .uns(uns2),
    .RD(rd2), .busy(busy2), .misalign(mis2), .test(test2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // we, a, size, uns, wd, chk_rd, rd (this cycle, pre-edge), mis
    vecs[0]  = '{1'b1, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b1, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0, 2'b10, 1'b0, 32'h0,        1'b1, 32'h11223344, 1'b0};
    vecs[2]  = '{1'b1, 32'h1, 2'b00, 1'b0, 32'h000000AA, 1'b1, 32'h00000033, 1'b0};
    vecs[3]  = '{1'b1, 32'h2, 2'b01, 1'b0, 32'h0000BEEF, 1'b1, 32'h00001122, 1'b0};
    vecs[4]  = '{1'b0, 32'h0, 2'b10, 1'b0, 32'h0,        1'b1, 32'hBEEFAA44, 1'b0};
    vecs[5]  = '{1'b1, 32'h4, 2'b10, 1'b0, 32'h80FF7F01, 1'b1, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b0, 32'h5, 2'b00, 1'b0, 32'h0,        1'b1, 32'h0000007F, 1'b0};
    vecs[7]  = '{1'b0, 32'h6, 2'b00, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{1'b0, 32'h6, 2'b00, 1'b1, 32'h0,        1'b1, 32'h000000FF, 1'b0};
    vecs[9]  = '{1'b0, 32'h6, 2'b01, 1'b0, 32'h0,        1'b1, 32'hFFFF80FF, 1'b0};
    vecs[10] = '{1'b0, 32'h6, 2'b01, 1'b1, 32'h0,        1'b1, 32'h000080FF, 1'b0};
    vecs[11] = '{1'b0, 32'h7, 2'b00, 1'b0, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
    vecs[12] = '{1'b0, 32'h4, 2'b01, 1'b0, 32'h0,        1'b1, 32'h00007F01, 1'b0};
    vecs[13] = '{1'b1, 32'h3, 2'b01, 1'b0, 32'h00001234, 1'b1, 32'h00000000, 1'b1};
    vecs[14] = '{1'b1, 32'h2, 2'b10, 1'b0, 32'hCAFEF00D, 1'b1, 32'h00000000, 1'b1};
    vecs[15] = '{1'b1, 32'h0, 2'b11, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1};
    vecs[16] = '{1'b0, 32'h0, 2'b10, 1'b0, 32'h0,        1'b1, 32'hBEEFAA44, 1'b0};
    vecs[17] = '{1'b1, 32'h2, 2'b01, 1'b0, 32'h00001234, 1'b1, 32'hFFFFBEEF, 1'b0};
    vecs[18] = '{1'b0, 32'h0, 2'b10, 1'b0, 32'h0,        1'b1, 32'h1234AA44, 1'b0};
    vecs[19] = '{1'b0, 32'h1, 2'b01, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1};
    vecs[20] = '{1'b0, 32'h3, 2'b00, 1'b1, 32'h0,        1'b1, 32'h00000012, 1'b0};
    vecs[21] = '{1'b1, 32'h43, 2'b00, 1'b0, 32'h00000077, 1'b1, 32'h00000012, 1'b0};
    vecs[22] = '{1'b0, 32'h0, 2'b10, 1'b0, 32'h0,        1'b1, 32'h7734AA44, 1'b0};

    reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0; size = 2'b10; uns = 1'b0;
    reset2 = 1'b1; we2 = 1'b0; a2 = 32'h0; wd2 = 32'h0; size2 = 2'b10; uns2 = 1'b0;

    // Clear timing with a dropped store while busy
    tick();
    tick();
    chk("busy_in_reset", {31'b0, busy}, 32'h1);
    chk("rd_in_reset", rd, 32'h0);
    chk("nc_busy_in_reset", {31'b0, busy2}, 32'h0);
    reset = 1'b0; reset2 = 1'b0;
    a = 32'h8; wd = 32'hDEADBEEF; we = 1'b1;
    chk("busy_after_release", {31'b0, busy}, 32'h1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
      if (n >= 3) we = 1'b0;
    end
    chk("clear_len", n, 32'd16);
    we = 1'b0; wd = 32'h0;
    for (int i = 0; i < 16; i++) begin
      a = i * 4;
      #1;
      chk($sformatf("cleared_w%0d", i), rd, 32'h0);
    end
    chk("test_after_clear", {16'b0, test}, 32'h0);

    // Table-driven lanes, extension, misalignment and wrap
    for (int i = 0; i < 23; i++) begin
      we = vecs[i].we; a = vecs[i].a; size = vecs[i].size;
      uns = vecs[i].uns; wd = vecs[i].wd;
      #1;
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d_mis", i), {31'b0, misalign}, {31'b0, vecs[i].mis});
      tick();
    end
    we = 1'b0; uns = 1'b0; size = 2'b10; a = 32'h0;
    #1;
    chk("test_live", {16'b0, test}, 32'h0000AA44);

    // Mid-clear reset restarts the sequence
    tick();
    reset = 1'b1;
    tick();
    chk("busy_reset2", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    repeat (5) tick();
    chk("busy_midclear", {31'b0, busy}, 32'h1);
    chk("test_cleared_live", {16'b0, test}, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("restart_clear_len", n, 32'd16);

    // Address wrap: 0x40 aliases word 0 for DEPTH=16
    a = 32'h40; wd = 32'h5A5A5A5A; we = 1'b1; size = 2'b10;
    tick();
    we = 1'b0; a = 32'h0;
    #1;
    chk("wrap_rd", rd, 32'h5A5A5A5A);
    chk("wrap_test", {16'b0, test}, 32'h00005A5A);

    // CLEAR_ON_RESET=0 keeps contents across reset
    a2 = 32'hC; wd2 = 32'h12345678; we2 = 1'b1;
    tick();
    we2 = 1'b0;
    reset2 = 1'b1;
    tick();
    chk("nc_busy_reset", {31'b0, busy2}, 32'h0);
    reset2 = 1'b0;
    tick();
    chk("nc_busy_after", {31'b0, busy2}, 32'h0);
    chk("nc_word3", rd2, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
